// File: rtl/regfile_exec.sv
// Execute/write-back stage: 8-entry register file, ALU, and a 4-state sequencer
// (IDLE -> READ -> EXEC -> WB) that pulses DONE on each register write-back.
module regfile_exec #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              START,
    input  logic [2:0]        SRC_REG1,
    input  logic [2:0]        SRC_REG2,
    input  logic [3:0]        CMD,
    input  logic [2:0]        DEST_REG,
    input  logic              LD_EN,
    input  logic [2:0]        LD_ADDR,
    input  logic [DATA_W-1:0] LD_DATA,
    input  logic [2:0]        DBG_ADDR,
    output logic [DATA_W-1:0] DBG_DATA,
    output logic [DATA_W-1:0] RESULT,
    output logic              ZERO,
    output logic              CARRY,
    output logic              BUSY,
    output logic              DONE
);

    localparam int unsigned RF_DEPTH = 8;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned CMD_W    = 4;
    localparam int unsigned SUM_W    = DATA_W + 1;

    localparam logic [CMD_W-1:0] OP_ADD  = 4'h0;
    localparam logic [CMD_W-1:0] OP_SUB  = 4'h1;
    localparam logic [CMD_W-1:0] OP_AND  = 4'h2;
    localparam logic [CMD_W-1:0] OP_OR   = 4'h3;
    localparam logic [CMD_W-1:0] OP_XOR  = 4'h4;
    localparam logic [CMD_W-1:0] OP_NOTA = 4'h5;
    localparam logic [CMD_W-1:0] OP_SHL  = 4'h6;
    localparam logic [CMD_W-1:0] OP_ASR  = 4'h7;
    localparam logic [CMD_W-1:0] OP_MOVA = 4'h8;
    localparam logic [CMD_W-1:0] OP_NOR  = 4'h9;
    localparam logic [CMD_W-1:0] OP_INC  = 4'hA;
    localparam logic [CMD_W-1:0] OP_DEC  = 4'hB;
    localparam logic [CMD_W-1:0] OP_MOVB = 4'hC;
    localparam logic [CMD_W-1:0] OP_SLT  = 4'hD;
    localparam logic [CMD_W-1:0] OP_LSR  = 4'hE;
    localparam logic [CMD_W-1:0] OP_NAND = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_e;

    state_e              state_q,  state_d;
    logic [ADDR_W-1:0]   src1_q,   src1_d;
    logic [ADDR_W-1:0]   src2_q,   src2_d;
    logic [ADDR_W-1:0]   dest_q,   dest_d;
    logic [CMD_W-1:0]    cmd_q,    cmd_d;
    logic [DATA_W-1:0]   a_q,      a_d;
    logic [DATA_W-1:0]   b_q,      b_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                zero_q,   zero_d;
    logic                carry_q,  carry_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;
    logic [DATA_W-1:0]   rf_q [RF_DEPTH];
    logic [DATA_W-1:0]   rf_d [RF_DEPTH];

    logic [DATA_W-1:0]   alu_res;
    logic                alu_carry;

    // ALU on the operands latched in READ; carry doubles as borrow for SUB/DEC
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (cmd_q)
            OP_ADD:  {alu_carry, alu_res} = SUM_W'(a_q) + SUM_W'(b_q);
            OP_SUB:  begin
                alu_res   = a_q - b_q;
                alu_carry = (a_q < b_q);
            end
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_NOTA: alu_res = ~a_q;
            OP_SHL:  alu_res = {a_q[DATA_W-2:0], 1'b0};
            OP_ASR:  alu_res = {a_q[DATA_W-1], a_q[DATA_W-1:1]};
            OP_MOVA: alu_res = a_q;
            OP_NOR:  alu_res = ~(a_q | b_q);
            OP_INC:  {alu_carry, alu_res} = SUM_W'(a_q) + SUM_W'(1);
            OP_DEC:  begin
                alu_res   = a_q - DATA_W'(1);
                alu_carry = (a_q == '0);
            end
            OP_MOVB: alu_res = b_q;
            OP_SLT:  alu_res = DATA_W'($signed(a_q) < $signed(b_q));
            OP_LSR:  alu_res = {1'b0, a_q[DATA_W-1:1]};
            OP_NAND: alu_res = ~(a_q & b_q);
        endcase
    end

    // Sequencer next-state, register-file write and output flag updates
    always_comb begin
        state_d  = state_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        dest_d   = dest_q;
        cmd_d    = cmd_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        rf_d     = rf_q;
        case (state_q)
            S_IDLE: begin
                if (LD_EN) begin
                    rf_d[LD_ADDR] = LD_DATA;
                end
                if (START) begin
                    src1_d  = SRC_REG1;
                    src2_d  = SRC_REG2;
                    cmd_d   = CMD;
                    dest_d  = DEST_REG;
                    busy_d  = 1'b1;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                a_d     = rf_q[src1_q];
                b_d     = rf_q[src2_q];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                result_d = alu_res;
                zero_d   = (alu_res == '0);
                carry_d  = alu_carry;
                state_d  = S_WB;
            end
            S_WB: begin
                rf_d[dest_q] = result_q;
                done_d       = 1'b1;
                busy_d       = 1'b0;
                state_d      = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight write-back
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            src1_q   <= '0;
            src2_q   <= '0;
            dest_q   <= '0;
            cmd_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rf_q     <= '{default: '0};
        end else begin
            state_q  <= state_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            dest_q   <= dest_d;
            cmd_q    <= cmd_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rf_q     <= rf_d;
        end
    end

    assign DBG_DATA = rf_q[DBG_ADDR];
    assign RESULT   = result_q;
    assign ZERO     = zero_q;
    assign CARRY    = carry_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;

endmodule

// File: tb/tb_regfile_exec.sv
// Self-checking bench for regfile_exec: directed vector table, multi-cycle
// corner sequences, and random operations against an arithmetic reference model.
module tb_regfile_exec;

    logic       clk = 1'b0;
    logic       rst;
    logic       START;
    logic [2:0] SRC_REG1, SRC_REG2, DEST_REG;
    logic [3:0] CMD;
    logic       LD_EN;
    logic [2:0] LD_ADDR;
    logic [7:0] LD_DATA;
    logic [2:0] DBG_ADDR;
    logic [7:0] DBG_DATA, RESULT;
    logic       ZERO, CARRY, BUSY, DONE;

    int n_checks = 0;
    int n_fail   = 0;
    int model_rf [8];

    regfile_exec #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst), .START(START),
        .SRC_REG1(SRC_REG1), .SRC_REG2(SRC_REG2), .CMD(CMD), .DEST_REG(DEST_REG),
        .LD_EN(LD_EN), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA),
        .DBG_ADDR(DBG_ADDR), .DBG_DATA(DBG_DATA),
        .RESULT(RESULT), .ZERO(ZERO), .CARRY(CARRY), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] s1, s2;
        logic [3:0] cmd;
        logic [2:0] d;
        logic [7:0] a, b, res;
        logic       z, c;
    } vec_t;

    vec_t tbl [20];

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference ALU from the opcode table, using plain integer arithmetic
    function automatic void ref_alu(input int a, input int b, input int cmd,
                                    output int r, output int c);
        int sa, sb;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        c = 0;
        case (cmd)
            0:  begin r = a + b; c = (r > 255) ? 1 : 0; end
            1:  begin r = a - b; c = (a < b) ? 1 : 0; end
            2:  r = a & b;
            3:  r = a | b;
            4:  r = a ^ b;
            5:  r = 255 - a;
            6:  r = a * 2;
            7:  r = (sa < 0) ? (sa - 1) / 2 : sa / 2;
            8:  r = a;
            9:  r = 255 - (a | b);
            10: begin r = a + 1; c = (r > 255) ? 1 : 0; end
            11: begin r = a - 1; c = (a == 0) ? 1 : 0; end
            12: r = b;
            13: r = (sa < sb) ? 1 : 0;
            14: r = a / 2;
            default: r = 255 - (a & b);
        endcase
        r = r & 255;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) model_rf[i] = 0;
    endtask

    task automatic load(input logic [2:0] addr, input logic [7:0] data);
        @(negedge clk);
        LD_EN = 1'b1; LD_ADDR = addr; LD_DATA = data;
        @(negedge clk);
        LD_EN = 1'b0;
        model_rf[addr] = int'(data);
    endtask

    task automatic check_reg(input string nm, input logic [2:0] addr, input int exp);
        DBG_ADDR = addr;
        #1;
        check(nm, int'(DBG_DATA), exp);
    endtask

    // One operation: checks BUSY after accept, accept-to-DONE latency, flags and write-back
    task automatic run_op(input string nm, input logic [2:0] s1, input logic [2:0] s2,
                          input logic [3:0] cmd, input logic [2:0] d,
                          input int er, input int ez, input int ec);
        int lat;
        @(negedge clk);
        START = 1'b1; SRC_REG1 = s1; SRC_REG2 = s2; CMD = cmd; DEST_REG = d;
        @(negedge clk);
        START = 1'b0;
        check({nm, ".busy"}, int'(BUSY), 1);
        lat = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (DONE) begin
                lat = n;
                break;
            end
        end
        check({nm, ".latency"}, lat, 3);
        if (lat != 0) begin
            check({nm, ".result"}, int'(RESULT), er);
            check({nm, ".zero"}, int'(ZERO), ez);
            check({nm, ".carry"}, int'(CARRY), ec);
            check({nm, ".busy_wb"}, int'(BUSY), 0);
            check_reg({nm, ".rf_dest"}, d, er);
        end
        model_rf[d] = er;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, c, a, b;
        logic [2:0] s1, s2, d;
        logic [3:0] cmd;
        logic [11:0] done_seen;
        logic [11:0] done_exp;

        rst = 1'b0; START = 1'b0; SRC_REG1 = '0; SRC_REG2 = '0; CMD = '0; DEST_REG = '0;
        LD_EN = 1'b0; LD_ADDR = '0; LD_DATA = '0; DBG_ADDR = '0;

        //            s1    s2    cmd    d     a      b      res    z     c
        tbl[0]  = '{3'd2, 3'd3, 4'h0, 3'd1, 8'h05, 8'h07, 8'h0C, 1'b0, 1'b0};
        tbl[1]  = '{3'd4, 3'd5, 4'h0, 3'd6, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b1};
        tbl[2]  = '{3'd1, 3'd2, 4'h1, 3'd7, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1};
        tbl[3]  = '{3'd1, 3'd2, 4'h2, 3'd3, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0};
        tbl[4]  = '{3'd1, 3'd2, 4'h3, 3'd3, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0};
        tbl[5]  = '{3'd1, 3'd2, 4'h4, 3'd3, 8'hAA, 8'hAA, 8'h00, 1'b1, 1'b0};
        tbl[6]  = '{3'd1, 3'd2, 4'h5, 3'd3, 8'h0F, 8'h00, 8'hF0, 1'b0, 1'b0};
        tbl[7]  = '{3'd1, 3'd2, 4'h6, 3'd3, 8'h81, 8'h00, 8'h02, 1'b0, 1'b0};
        tbl[8]  = '{3'd1, 3'd2, 4'h7, 3'd3, 8'h82, 8'h00, 8'hC1, 1'b0, 1'b0};
        tbl[9]  = '{3'd1, 3'd2, 4'h8, 3'd3, 8'h5A, 8'h00, 8'h5A, 1'b0, 1'b0};
        tbl[10] = '{3'd1, 3'd2, 4'h9, 3'd3, 8'h0F, 8'h30, 8'hC0, 1'b0, 1'b0};
        tbl[11] = '{3'd1, 3'd2, 4'hA, 3'd3, 8'h7F, 8'h00, 8'h80, 1'b0, 1'b0};
        tbl[12] = '{3'd1, 3'd2, 4'hB, 3'd3, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b1};
        tbl[13] = '{3'd1, 3'd2, 4'hC, 3'd3, 8'h00, 8'h99, 8'h99, 1'b0, 1'b0};
        tbl[14] = '{3'd1, 3'd2, 4'hD, 3'd3, 8'h80, 8'h01, 8'h01, 1'b0, 1'b0};
        tbl[15] = '{3'd1, 3'd2, 4'hD, 3'd3, 8'h01, 8'h80, 8'h00, 1'b1, 1'b0};
        tbl[16] = '{3'd1, 3'd2, 4'hE, 3'd3, 8'h82, 8'h00, 8'h41, 1'b0, 1'b0};
        tbl[17] = '{3'd1, 3'd2, 4'hF, 3'd3, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0};
        tbl[18] = '{3'd1, 3'd2, 4'h1, 3'd3, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0};
        tbl[19] = '{3'd4, 3'd4, 4'h0, 3'd4, 8'h81, 8'h81, 8'h02, 1'b0, 1'b1};

        // Reset state
        do_reset();
        check("rst.busy", int'(BUSY), 0);
        check("rst.done", int'(DONE), 0);
        check("rst.result", int'(RESULT), 0);
        check("rst.zero", int'(ZERO), 0);
        check("rst.carry", int'(CARRY), 0);
        for (int i = 0; i < 8; i++) check_reg($sformatf("rst.rf%0d", i), 3'(i), 0);

        // Directed opcode table
        for (int i = 0; i < 20; i++) begin
            load(tbl[i].s1, tbl[i].a);
            load(tbl[i].s2, tbl[i].b);
            run_op($sformatf("vec%0d", i), tbl[i].s1, tbl[i].s2, tbl[i].cmd, tbl[i].d,
                   int'(tbl[i].res), int'(tbl[i].z), int'(tbl[i].c));
        end

        // INC wraps FF->00 with carry, DEC wraps back with borrow, in place on R0
        load(3'd0, 8'hFF);
        run_op("inc_wrap", 3'd0, 3'd0, 4'hA, 3'd0, 'h00, 1, 1);
        run_op("dec_wrap", 3'd0, 3'd0, 4'hB, 3'd0, 'hFF, 0, 1);

        // START held high: back-to-back ops, chained INC on R1, DONE every 4th cycle
        load(3'd1, 8'h00);
        @(negedge clk);
        START = 1'b1; SRC_REG1 = 3'd1; SRC_REG2 = 3'd1; CMD = 4'hA; DEST_REG = 3'd1;
        done_seen = '0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            done_seen[j] = DONE;
        end
        START = 1'b0;
        done_exp = 12'b1000_1000_1000;
        check("held.done_pattern", int'(done_seen), int'(done_exp));
        check_reg("held.r1", 3'd1, 3);
        model_rf[1] = 3;

        // LD_EN while busy is ignored
        load(3'd5, 8'h11);
        @(negedge clk);
        START = 1'b1; SRC_REG1 = 3'd5; SRC_REG2 = 3'd5; CMD = 4'h8; DEST_REG = 3'd6;
        @(negedge clk);
        START = 1'b0;
        LD_EN = 1'b1; LD_ADDR = 3'd5; LD_DATA = 8'h77;
        for (int j = 0; j < 3; j++) @(negedge clk);
        LD_EN = 1'b0;
        check("busyload.done", int'(DONE), 1);
        check_reg("busyload.r5", 3'd5, 'h11);
        check_reg("busyload.r6", 3'd6, 'h11);
        model_rf[6] = 'h11;

        // LD_EN and START on the same edge: READ sees the freshly loaded value
        load(3'd6, 8'h10);
        @(negedge clk);
        LD_EN = 1'b1; LD_ADDR = 3'd6; LD_DATA = 8'h21;
        START = 1'b1; SRC_REG1 = 3'd6; SRC_REG2 = 3'd6; CMD = 4'h8; DEST_REG = 3'd7;
        @(negedge clk);
        LD_EN = 1'b0; START = 1'b0;
        for (int j = 0; j < 3; j++) @(negedge clk);
        check("ldstart.done", int'(DONE), 1);
        check("ldstart.result", int'(RESULT), 'h21);
        check_reg("ldstart.r7", 3'd7, 'h21);

        // Reset during EXEC: no DONE, no write-back, sequencer back in IDLE
        do_reset();
        load(3'd3, 8'h09);
        @(negedge clk);
        START = 1'b1; SRC_REG1 = 3'd3; SRC_REG2 = 3'd3; CMD = 4'h0; DEST_REG = 3'd2;
        @(negedge clk);
        START = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) model_rf[i] = 0;
        done_seen = '0;
        for (int j = 0; j < 6; j++) begin
            done_seen[j] = DONE;
            @(negedge clk);
        end
        check("midrst.no_done", int'(done_seen), 0);
        check("midrst.busy", int'(BUSY), 0);
        check_reg("midrst.r2", 3'd2, 0);
        check_reg("midrst.r3", 3'd3, 0);
        run_op("midrst.idle", 3'd0, 3'd0, 4'hA, 3'd4, 'h01, 0, 0);

        // Random operations against the reference model
        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 2) != 0) load(3'($urandom_range(0, 7)), 8'($urandom));
            s1  = 3'($urandom_range(0, 7));
            s2  = 3'($urandom_range(0, 7));
            d   = 3'($urandom_range(0, 7));
            cmd = 4'($urandom_range(0, 15));
            a = model_rf[s1];
            b = model_rf[s2];
            ref_alu(a, b, int'(cmd), r, c);
            run_op($sformatf("rand%0d_cmd%0h", t, cmd), s1, s2, cmd, d, r, (r == 0) ? 1 : 0, c);
        end
        for (int i = 0; i < 8; i++) check_reg($sformatf("final.rf%0d", i), 3'(i), model_rf[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
